// File: rtl/instruction_memory_arbiter_pkg.sv
// rtl/instruction_memory_arbiter_pkg.sv - shared instruction package: opcode encoding and field widths
package instruction_memory_arbiter_pkg;

  localparam int OPCODE_WIDTH  = 8;
  localparam int OPERAND_WIDTH = 8;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    CHAR  = 8'h00,
    SPLIT = 8'h01,
    JMP   = 8'h02,
    MATCH = 8'h03
  } opcode_t;

endpackage

// File: rtl/instruction_memory_arbiter_ram.sv
// rtl/instruction_memory_arbiter_ram.sv - single-port instruction RAM, synchronous read, no reset
module instruction_ram #(
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic                         we,
  input  logic [MEMORY_ADDR_WIDTH-1:0] addr,
  input  logic [MEMORY_WIDTH-1:0]      wdata,
  output logic [MEMORY_WIDTH-1:0]      rdata
);

  logic [MEMORY_WIDTH-1:0] mem_q [2**MEMORY_ADDR_WIDTH];
  logic [MEMORY_WIDTH-1:0] rdata_q;

  // A write cycle leaves the read register untouched, so the last fetched word survives a load.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instruction_memory_arbiter.sv
// rtl/instruction_memory_arbiter.sv - round-robin fetch arbiter and program-load port for the instruction RAM
module instruction_memory_arbiter
  import instruction_memory_arbiter_pkg::*;
#(
  parameter int N_BB              = 4,
  parameter int MEMORY_WIDTH      = OPCODE_WIDTH + OPERAND_WIDTH,
  parameter int MEMORY_ADDR_WIDTH = 11
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_BB-1:0]                   bb_memory_valid,
  input  logic [N_BB*MEMORY_ADDR_WIDTH-1:0] bb_memory_addr,
  output logic [N_BB-1:0]                   bb_memory_ready,
  output logic [MEMORY_WIDTH-1:0]           bb_memory_data,
  input  logic                              load_mode,
  input  logic                              load_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0]      load_addr,
  input  logic [MEMORY_WIDTH-1:0]           load_data,
  output logic                              load_ready
);

  typedef enum logic {ST_RUN, ST_LOAD} state_t;

  localparam int PTR_W = (N_BB > 1) ? $clog2(N_BB) : 1;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        rr_q, rr_d;
  logic [N_BB-1:0]         last_grant_q, last_grant_d;
  logic                    rd_pending_q, rd_pending_d;
  logic [MEMORY_WIDTH-1:0] data_q, data_d;

  logic [MEMORY_ADDR_WIDTH-1:0] addr_arr [N_BB];
  logic [N_BB-1:0]              eligible;
  logic [N_BB-1:0]              grant;
  logic [PTR_W-1:0]             grant_idx;
  logic                         grant_any;
  int                           idx;

  logic                         ram_en, ram_we;
  logic [MEMORY_ADDR_WIDTH-1:0] ram_addr;
  logic [MEMORY_WIDTH-1:0]      ram_rdata;

  for (genvar g = 0; g < N_BB; g++) begin : g_addr
    assign addr_arr[g] = bb_memory_addr[g*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
  end

  // Masking last cycle's grant guarantees a handshaken request is never served twice.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    eligible  = bb_memory_valid & ~last_grant_q;
    if (state_q == ST_RUN) begin
      for (int k = 0; k < N_BB; k++) begin
        idx = (int'(rr_q) + k) % N_BB;
        if (!grant_any && eligible[idx]) begin
          grant_any  = 1'b1;
          grant_idx  = PTR_W'(idx);
          grant[idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (load_mode)  state_d = ST_LOAD;
      ST_LOAD: if (!load_mode) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase

    rr_d = rr_q;
    if (grant_any) begin
      rr_d = (grant_idx == PTR_W'(N_BB-1)) ? '0 : grant_idx + PTR_W'(1);
    end

    last_grant_d = grant;
    rd_pending_d = grant_any;
    data_d       = rd_pending_q ? ram_rdata : data_q;

    load_ready = (state_q == ST_LOAD) && load_valid;
    ram_we     = load_ready;
    ram_en     = grant_any || load_ready;
    ram_addr   = load_ready ? load_addr : addr_arr[grant_idx];
  end

  assign bb_memory_ready = grant;
  assign bb_memory_data  = data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      rr_q         <= '0;
      last_grant_q <= '0;
      rd_pending_q <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      last_grant_q <= last_grant_d;
      rd_pending_q <= rd_pending_d;
      data_q       <= data_d;
    end
  end

  instruction_ram #(
    .MEMORY_WIDTH     (MEMORY_WIDTH),
    .MEMORY_ADDR_WIDTH(MEMORY_ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(load_data),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_instruction_memory_arbiter.sv
// tb/tb_instruction_memory_arbiter.sv - self-checking bench for instruction_memory_arbiter
module tb_instruction_memory_arbiter;
  import instruction_memory_arbiter_pkg::*;

  localparam int N_BB = 4;
  localparam int W    = 16;
  localparam int AW   = 11;

  localparam logic [W-1:0] W10  = 16'h0110;
  localparam logic [W-1:0] W11  = 16'h0211;
  localparam logic [W-1:0] W12  = {MATCH, 8'hEF};
  localparam logic [W-1:0] W7FF = 16'h3C5A;
  localparam logic [W-1:0] W000 = 16'h0077;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_BB-1:0]   bb_memory_valid;
  logic [N_BB*AW-1:0] bb_memory_addr;
  logic [N_BB-1:0]   bb_memory_ready;
  logic [W-1:0]      bb_memory_data;
  logic              load_mode, load_valid, load_ready;
  logic [AW-1:0]     load_addr;
  logic [W-1:0]      load_data;

  instruction_memory_arbiter #(
    .N_BB(N_BB), .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .bb_memory_valid(bb_memory_valid), .bb_memory_addr(bb_memory_addr),
    .bb_memory_ready(bb_memory_ready), .bb_memory_data(bb_memory_data),
    .load_mode(load_mode), .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .load_ready(load_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_BB-1:0] valid;
    logic [N_BB-1:0] exp_ready;
    logic [W-1:0]    exp_data;
  } vec_t;

  vec_t              tbl [8];
  int                n_cmp = 0;
  int                n_err = 0;
  logic [W-1:0]      mem_m [int];
  logic [AW-1:0]     addrs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bb_memory_addr[i*AW +: AW] = a;
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [W-1:0] d);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    sample();
    chk("load_ready_in_load", 32'(load_ready), 32'd1);
    mem_m[int'(a)] = d;
    addrs.push_back(a);
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    int              ptr;
    int              g;
    int              max_wait;
    logic [W-1:0]    exp_data, exp_next;
    logic [N_BB-1:0] er;
    bit              pend [N_BB];
    bit              cool [N_BB];
    logic [AW-1:0]   paddr [N_BB];
    int              wait_cnt [N_BB];

    tbl[0] = '{4'b0111, 4'b0001, W7FF};
    tbl[1] = '{4'b0110, 4'b0010, W10};
    tbl[2] = '{4'b0100, 4'b0100, W11};
    tbl[3] = '{4'b0000, 4'b0000, W12};
    tbl[4] = '{4'b1000, 4'b1000, W12};
    tbl[5] = '{4'b1010, 4'b0010, W7FF};
    tbl[6] = '{4'b1000, 4'b1000, W11};
    tbl[7] = '{4'b0000, 4'b0000, W7FF};

    reset = 1'b1;
    bb_memory_valid = '0;
    bb_memory_addr  = '0;
    load_mode = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    tick(); tick();
    sample();
    chk("reset_ready", 32'(bb_memory_ready), 32'd0);
    chk("reset_data", 32'(bb_memory_data), 32'd0);
    chk("reset_load_ready", 32'(load_ready), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    load_mode = 1'b1;
    tick();
    sample();
    chk("load_idle_ready", 32'(load_ready), 32'd0);
    tick();
    do_load(11'h012, W12);
    do_load(11'h010, W10);
    do_load(11'h011, W11);
    do_load(11'h7FF, W7FF);
    do_load(11'h000, W000);
    for (int i = 0; i < 12; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(32'h020, 32'h7FE));
      do_load(a, W'($urandom));
    end
    load_mode = 1'b0;
    tick();

    set_addr(0, 11'h012);
    bb_memory_valid = 4'b0001;
    sample();
    chk("t2_ready", 32'(bb_memory_ready), 32'b0001);
    tick();
    bb_memory_valid = '0;
    sample();
    chk("t2_data", 32'(bb_memory_data), 32'(W12));
    tick();

    set_addr(0, 11'h010); set_addr(1, 11'h011); set_addr(2, 11'h012); set_addr(3, 11'h7FF);
    bb_memory_valid = 4'b1000;
    sample();
    chk("wrap_ready", 32'(bb_memory_ready), 32'b1000);
    tick();

    for (int r = 0; r < 8; r++) begin
      bb_memory_valid = tbl[r].valid;
      sample();
      chk($sformatf("tbl%0d_ready", r), 32'(bb_memory_ready), 32'(tbl[r].exp_ready));
      chk($sformatf("tbl%0d_data", r), 32'(bb_memory_data), 32'(tbl[r].exp_data));
      tick();
    end

    bb_memory_valid = 4'b0010;
    load_mode = 1'b1;
    sample();
    chk("t5_last_run_grant", 32'(bb_memory_ready), 32'b0010);
    tick();
    bb_memory_valid = '0;
    sample();
    chk("t5_inflight_data", 32'(bb_memory_data), 32'(W11));
    tick();
    bb_memory_valid = 4'b1101;
    for (int c = 0; c < 4; c++) begin
      sample();
      chk("t5_load_ready0", 32'(bb_memory_ready), 32'd0);
      chk("t5_load_hold", 32'(bb_memory_data), 32'(W11));
      tick();
    end
    load_mode = 1'b0;
    sample();
    chk("t5_exit_cycle", 32'(bb_memory_ready), 32'd0);
    tick();
    sample();
    chk("t5_first_run", 32'(bb_memory_ready), 32'b0100);
    tick();
    bb_memory_valid = 4'b1001;
    sample();
    chk("t5_next3", 32'(bb_memory_ready), 32'b1000);
    chk("t5_data2", 32'(bb_memory_data), 32'(W12));
    tick();
    bb_memory_valid = 4'b0001;
    sample();
    chk("t5_next0", 32'(bb_memory_ready), 32'b0001);
    chk("t5_data3", 32'(bb_memory_data), 32'(W7FF));
    tick();
    bb_memory_valid = '0;
    sample();
    chk("t5_data0", 32'(bb_memory_data), 32'(W10));
    tick();

    load_valid = 1'b1; load_addr = 11'h012; load_data = 16'hFFFF;
    sample();
    chk("t6_load_ready_run", 32'(load_ready), 32'd0);
    tick();
    load_valid = 1'b0;
    set_addr(1, 11'h012);
    bb_memory_valid = 4'b0010;
    sample();
    chk("t6_ready", 32'(bb_memory_ready), 32'b0010);
    tick();
    bb_memory_valid = '0;
    sample();
    chk("t6_data", 32'(bb_memory_data), 32'(W12));
    tick();

    ptr = 2;
    exp_data = W12;
    max_wait = 0;
    for (int i = 0; i < N_BB; i++) begin
      pend[i] = 0; cool[i] = 0; paddr[i] = '0; wait_cnt[i] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N_BB; i++) begin
        if (!pend[i] && !cool[i] && $urandom_range(0, 2) == 0) begin
          pend[i]     = 1;
          paddr[i]    = addrs[$urandom_range(0, addrs.size() - 1)];
          wait_cnt[i] = 0;
        end
        bb_memory_valid[i] = pend[i];
        set_addr(i, paddr[i]);
      end
      load_valid = ($urandom_range(0, 7) == 0);
      load_addr  = AW'($urandom);
      load_data  = W'($urandom);
      g = -1;
      for (int k = 0; k < N_BB; k++) begin
        if (g < 0 && pend[(ptr + k) % N_BB]) g = (ptr + k) % N_BB;
      end
      er = (g >= 0) ? N_BB'(1 << g) : '0;
      sample();
      chk("rnd_ready", 32'(bb_memory_ready), 32'(er));
      chk("rnd_data", 32'(bb_memory_data), 32'(exp_data));
      chk("rnd_load_ready", 32'(load_ready), 32'd0);
      for (int i = 0; i < N_BB; i++) cool[i] = 0;
      if (g >= 0) begin
        exp_next = mem_m[int'(paddr[g])];
        pend[g] = 0;
        cool[g] = 1;
        ptr = (g + 1) % N_BB;
        exp_data = exp_next;
      end
      for (int i = 0; i < N_BB; i++) begin
        if (pend[i]) begin
          wait_cnt[i]++;
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
      end
      tick();
    end
    bb_memory_valid = '0;
    load_valid = 1'b0;
    chk("no_starvation", 32'(max_wait <= N_BB - 1), 32'd1);
    tick();

    set_addr(0, 11'h010);
    bb_memory_valid = 4'b1111;
    tick();
    bb_memory_valid = '0;
    tick();
    set_addr(0, 11'h000);
    bb_memory_valid = 4'b0001;
    sample();
    chk("t1_pre_grant", 32'(bb_memory_ready), 32'b0001);
    tick();
    bb_memory_valid = '0;
    reset = 1'b1;
    sample();
    chk("t1_reset_mid_read", 32'(bb_memory_data), 32'd0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      sample();
      chk("t1_idle_ready", 32'(bb_memory_ready), 32'd0);
      chk("t1_idle_data", 32'(bb_memory_data), 32'd0);
      chk("t1_idle_load_ready", 32'(load_ready), 32'd0);
    end
    tick();
    set_addr(0, 11'h010);
    bb_memory_valid = 4'b1111;
    sample();
    chk("t1_ptr_reset", 32'(bb_memory_ready), 32'b0001);
    tick();
    bb_memory_valid = '0;
    sample();
    chk("t1_post_reset_data", 32'(bb_memory_data), 32'(W10));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
